// File: rtl/issue_scoreboard.sv
// issue_scoreboard
//   Issue controller between decode and the execute/load-store datapath.
//   Tracks in-flight register writes with per-register latency countdowns.
//   Blocks issue on RAW/WAW hazards, while a branch is unresolved and after
//   a halt. Drives the fetch hold.
//
// Optional feature (compile-time macro SCB_FORWARD_EN):
//   defined   - a source is ready when its countdown is <= 1, because the
//               bypass covers the write cycle
//   undefined - a source is ready only when its countdown is 0
//
// Parameters:
//   ALU_LAT       cycles from issue until an ALU/immediate result is written (1..15)
//   LD_LAT        cycles from issue until a load result is written (1..15)
// Ports:
//   clk           clock; all state changes on the rising edge
//   rst           asynchronous, active-high reset
//   dec_valid     decode presents an instruction this cycle
//   dec_regWrite  instruction writes dec_destReg
//   dec_isLoad    the write uses LD_LAT instead of ALU_LAT
//   dec_isBranch  instruction is a branch
//   dec_halt      instruction is HALT
//   dec_useSrc1/2 the source operand is read
//   dec_destReg, dec_src1, dec_src2   register indices
//   br_resolve    one-cycle pulse: the outstanding branch is resolved
//   issue         instruction accepted this cycle
//   hold_if       fetch/decode must hold the current instruction
//   busy_mask     bit r is set while register r has a pending write
//   halted        machine halted and drained
//   stall_cycles  saturating count of stalled cycles
module issue_scoreboard #(
    parameter int unsigned ALU_LAT = 2,
    parameter int unsigned LD_LAT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic        dec_regWrite,
    input  logic        dec_isLoad,
    input  logic        dec_isBranch,
    input  logic        dec_halt,
    input  logic        dec_useSrc1,
    input  logic        dec_useSrc2,
    input  logic [3:0]  dec_destReg,
    input  logic [3:0]  dec_src1,
    input  logic [3:0]  dec_src2,
    input  logic        br_resolve,
    output logic        issue,
    output logic        hold_if,
    output logic [15:0] busy_mask,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN,
        S_BR_WAIT,
        S_DRAIN,
        S_HALTED
    } state_t;

    localparam logic [3:0] ALU_LAT_C = 4'(ALU_LAT);
    localparam logic [3:0] LD_LAT_C  = 4'(LD_LAT);

    state_t      state, state_nxt;
    logic [3:0]  cnt [16];
    logic        wr_eff;
    logic        src1_rdy, src2_rdy;
    logic        hazard;
    logic [3:0]  new_lat;

    // A HALT never writes, even when decode flags a register write.
    assign wr_eff  = dec_regWrite & ~dec_halt;
    assign new_lat = dec_isLoad ? LD_LAT_C : ALU_LAT_C;

    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            busy_mask[i] = (cnt[i] != 4'd0);
        end
    end

`ifdef SCB_FORWARD_EN
    assign src1_rdy = (cnt[dec_src1] <= 4'd1);
    assign src2_rdy = (cnt[dec_src2] <= 4'd1);
`else
    assign src1_rdy = (cnt[dec_src1] == 4'd0);
    assign src2_rdy = (cnt[dec_src2] == 4'd0);
`endif

    assign hazard  = (dec_useSrc1 & ~src1_rdy)
                   | (dec_useSrc2 & ~src2_rdy)
                   | (wr_eff & busy_mask[dec_destReg]);
    assign issue   = dec_valid & (state == S_RUN) & ~hazard;
    assign hold_if = (dec_valid & ~issue) | (state != S_RUN);

    // halted is raised in the first DRAIN cycle that sees no pending write,
    // one cycle ahead of the registered HALTED state, so a halt issued with
    // at most one cycle of outstanding writes reports halted on the next cycle.
    assign halted  = (state == S_HALTED) | ((state == S_DRAIN) & (busy_mask == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 16; i++) begin
                if (issue && wr_eff && (dec_destReg == 4'(i))) begin
                    cnt[i] <= new_lat;
                end else if (cnt[i] != 4'd0) begin
                    cnt[i] <= cnt[i] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (dec_valid && !issue && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_RUN: begin
                if (issue && dec_halt) begin
                    state_nxt = S_DRAIN;
                end else if (issue && dec_isBranch) begin
                    state_nxt = S_BR_WAIT;
                end
            end
            S_BR_WAIT: begin
                if (br_resolve) begin
                    state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                if (busy_mask == '0) begin
                    state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                state_nxt = S_HALTED;
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

endmodule
